// File: rtl/bus_master_if.sv
// Per-master shared-bus interface: request/grant, one-cycle address strobe, completion on slave ready.
// Optional local scratchpad bypass is enabled by defining BUS_MASTER_IF_SPM_EN.
module bus_master_if #(
    parameter int          ADDR_W  = 30,
    parameter int          DATA_W  = 32,
    parameter logic [2:0]  SPM_SEL = 3'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    output logic              busy,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_,
    input  logic              rw,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
`ifdef BUS_MASTER_IF_SPM_EN
    ,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_t;

`ifdef BUS_MASTER_IF_SPM_EN
    localparam bit SPM_EN = 1'b1;
`else
    localparam bit SPM_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_next;
    logic              req_q;
    logic              as_q;
    logic [DATA_W-1:0] rd_buf;
    logic              spm_hit;
    logic              valid_acc;

    assign spm_hit   = SPM_EN && (addr[ADDR_W-1:ADDR_W-3] == SPM_SEL);
    assign valid_acc = !as_ && !flush && !spm_hit;

    // Request and strobe drop the moment reset rises so the arbiter is never left holding a grant.
    assign bus_req_ = req_q | reset;
    assign bus_as_  = as_q | reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= 1'b1;
            as_q        <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_buf      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (valid_acc) begin
                        bus_addr    <= addr;
                        bus_rw      <= rw;
                        bus_wr_data <= wr_data;
                        req_q       <= 1'b0;
                    end
                end
                REQ: begin
                    if (!bus_grnt_) as_q <= 1'b0;
                end
                ACCESS: begin
                    as_q <= 1'b1;
                    if (!bus_rdy_) begin
                        req_q       <= 1'b1;
                        bus_addr    <= '0;
                        bus_wr_data <= '0;
                        bus_rw      <= 1'b1;
                        rd_buf      <= bus_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        rd_data    = '0;
        case (state)
            IDLE: begin
                if (valid_acc) begin
                    state_next = REQ;
                    busy       = 1'b1;
                end
`ifdef BUS_MASTER_IF_SPM_EN
                if (spm_hit) rd_data = spm_rd_data;
`endif
            end
            REQ: begin
                busy = 1'b1;
                if (!bus_grnt_) state_next = ACCESS;
            end
            ACCESS: begin
                busy = 1'b1;
                if (!bus_rdy_) begin
                    busy       = 1'b0;
                    rd_data    = bus_rd_data;
                    state_next = stall ? STALL : IDLE;
                end
            end
            STALL: begin
                rd_data = rd_buf;
                if (!stall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            busy    = 1'b0;
            rd_data = '0;
        end
    end

`ifdef BUS_MASTER_IF_SPM_EN
    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;
    assign spm_as_     = !((state == IDLE) && !as_ && !flush && spm_hit && !reset);
`endif

endmodule

// File: tb/tb_bus_master_if.sv
// Directed-vector bench for bus_master_if: each cycle's expected outputs are queued by the driver
// and popped/compared by an independent negedge monitor.
module tb_bus_master_if;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_ACC   = 2'd2;
    localparam logic [1:0] S_STALL = 2'd3;

    typedef struct packed {
        logic        as_n;
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wd;
        logic        stall;
        logic        flush;
        logic        grnt_n;
        logic        rdy_n;
        logic [31:0] brd;
        logic        rst;
    } in_t;

    typedef struct packed {
        logic        busy;
        logic        req_n;
        logic        as_n;
        logic [31:0] rd;
        logic [29:0] baddr;
        logic        brw;
        logic [31:0] bwd;
        logic [1:0]  st;
        logic        spm_as_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [29:0] addr;
    logic        as_;
    logic        rw;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        bus_req_;
    logic        bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
`ifdef BUS_MASTER_IF_SPM_EN
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;
`endif

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    bus_master_if dut (
`ifdef BUS_MASTER_IF_SPM_EN
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .spm_wr_data (spm_wr_data),
        .spm_rd_data (spm_rd_data),
`endif
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .busy        (busy),
        .addr        (addr),
        .as_         (as_),
        .rw          (rw),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_)
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic in_t vi(logic as_n, logic rw_i, logic [29:0] a, logic [31:0] wd,
                               logic st, logic fl, logic g, logic r, logic [31:0] brd, logic rs);
        in_t v;
        v = '{as_n: as_n, rw: rw_i, addr: a, wd: wd, stall: st, flush: fl,
              grnt_n: g, rdy_n: r, brd: brd, rst: rs};
        return v;
    endfunction

    function automatic exp_t ex(logic b, logic rq, logic sa, logic [31:0] rd, logic [29:0] ba,
                                logic brw, logic [31:0] bwd, logic [1:0] st, logic spm = 1'b1);
        exp_t e;
        e = '{busy: b, req_n: rq, as_n: sa, rd: rd, baddr: ba, brw: brw, bwd: bwd,
              st: st, spm_as_n: spm};
        return e;
    endfunction

    function automatic void check(string t, string f, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", t, f, act, expv);
        end
    endfunction

    // Driver
    task automatic step(input string tag, input in_t i, input exp_t e);
        as_         = i.as_n;
        rw          = i.rw;
        addr        = i.addr;
        wr_data     = i.wd;
        stall       = i.stall;
        flush       = i.flush;
        bus_grnt_   = i.grnt_n;
        bus_rdy_    = i.rdy_n;
        bus_rd_data = i.brd;
        reset       = i.rst;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, "busy",        {31'd0, busy},        {31'd0, e.busy});
            check(t, "bus_req_",    {31'd0, bus_req_},    {31'd0, e.req_n});
            check(t, "bus_as_",     {31'd0, bus_as_},     {31'd0, e.as_n});
            check(t, "rd_data",     rd_data,              e.rd);
            check(t, "bus_addr",    {2'd0, bus_addr},     {2'd0, e.baddr});
            check(t, "bus_rw",      {31'd0, bus_rw},      {31'd0, e.brw});
            check(t, "bus_wr_data", bus_wr_data,          e.bwd);
            check(t, "state",       {30'd0, 2'(dut.state)}, {30'd0, e.st});
`ifdef BUS_MASTER_IF_SPM_EN
            check(t, "spm_as_",     {31'd0, spm_as_},     {31'd0, e.spm_as_n});
`endif
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; addr = '0; as_ = 1'b1; rw = 1'b1;
        wr_data = '0; bus_grnt_ = 1'b1; bus_rd_data = '0; bus_rdy_ = 1'b1;
`ifdef BUS_MASTER_IF_SPM_EN
        spm_rd_data = 32'h55AA55AA;
`endif
        repeat (2) @(posedge clk);
        #1;

        // Reset held with an access presented: everything at reset values
        step("rst", vi(0, 1, 30'h55, 32'h1, 0, 0, 0, 0, 32'h9, 1), ex(0, 1, 1, 0, 0, 1, 0, S_IDLE));

        // Read, immediate grant and ready
        step("rd0", vi(0, 1, 30'hAB, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0), ex(1, 1, 1, 0, 0, 1, 0, S_IDLE));
        step("rd1", vi(1, 1, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0), ex(1, 0, 1, 0, 30'hAB, 1, 0, S_REQ));
        step("rd2", vi(1, 1, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0),
             ex(0, 0, 0, 32'hDEADBEEF, 30'hAB, 1, 0, S_ACC));
        step("rd3", vi(1, 1, 0, 0, 0, 0, 1, 1, 0, 0), ex(0, 1, 1, 0, 0, 1, 0, S_IDLE));

        // Write, grant delayed 3 cycles, ready delayed 2; pipeline inputs change while held
        step("wr0", vi(0, 0, 30'h100, 32'h12345678, 0, 0, 1, 1, 0, 0), ex(1, 1, 1, 0, 0, 1, 0, S_IDLE));
        step("wr1", vi(1, 1, 30'h3FF, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0),
             ex(1, 0, 1, 0, 30'h100, 0, 32'h12345678, S_REQ));
        step("wr2", vi(1, 1, 30'h3FF, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0),
             ex(1, 0, 1, 0, 30'h100, 0, 32'h12345678, S_REQ));
        step("wr3", vi(1, 1, 30'h3FF, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0),
             ex(1, 0, 1, 0, 30'h100, 0, 32'h12345678, S_REQ));
        step("wr4", vi(1, 1, 30'h3FF, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0),
             ex(1, 0, 1, 0, 30'h100, 0, 32'h12345678, S_REQ));
        step("wr5", vi(1, 1, 30'h3FF, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0),
             ex(1, 0, 0, 0, 30'h100, 0, 32'h12345678, S_ACC));
        step("wr6", vi(1, 1, 30'h3FF, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0),
             ex(1, 0, 1, 0, 30'h100, 0, 32'h12345678, S_ACC));
        step("wr7", vi(1, 1, 30'h3FF, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h0BADF00D, 0),
             ex(0, 0, 1, 32'h0BADF00D, 30'h100, 0, 32'h12345678, S_ACC));
        step("wr8", vi(1, 1, 0, 0, 0, 0, 1, 1, 0, 0), ex(0, 1, 1, 0, 0, 1, 0, S_IDLE));

        // Read completing under a 4-cycle pipeline stall
        step("st0", vi(0, 1, 30'h2A, 0, 0, 0, 0, 1, 0, 0), ex(1, 1, 1, 0, 0, 1, 0, S_IDLE));
        step("st1", vi(1, 1, 0, 0, 0, 0, 0, 1, 0, 0), ex(1, 0, 1, 0, 30'h2A, 1, 0, S_REQ));
        step("st2", vi(1, 1, 0, 0, 1, 0, 1, 0, 32'h13579BDF, 0),
             ex(0, 0, 0, 32'h13579BDF, 30'h2A, 1, 0, S_ACC));
        step("st3", vi(1, 1, 0, 0, 1, 0, 1, 1, 32'hFFFFFFFF, 0), ex(0, 1, 1, 32'h13579BDF, 0, 1, 0, S_STALL));
        step("st4", vi(1, 1, 0, 0, 1, 0, 1, 1, 32'h0, 0), ex(0, 1, 1, 32'h13579BDF, 0, 1, 0, S_STALL));
        step("st5", vi(1, 1, 0, 0, 1, 0, 1, 1, 32'h0, 0), ex(0, 1, 1, 32'h13579BDF, 0, 1, 0, S_STALL));
        step("st6", vi(1, 1, 0, 0, 0, 0, 1, 1, 32'h0, 0), ex(0, 1, 1, 32'h13579BDF, 0, 1, 0, S_STALL));
        step("st7", vi(1, 1, 0, 0, 0, 0, 1, 1, 0, 0), ex(0, 1, 1, 0, 0, 1, 0, S_IDLE));

        // Flush in IDLE blocks the access; flush in REQ/ACCESS does not abort it
        step("fl0", vi(0, 1, 30'h77, 0, 0, 1, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 1, 0, S_IDLE));
        step("fl1", vi(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 1, 0, S_IDLE));
        step("fl2", vi(0, 0, 30'h1C, 32'hA5A5A5A5, 0, 0, 0, 1, 0, 0), ex(1, 1, 1, 0, 0, 1, 0, S_IDLE));
        step("fl3", vi(1, 1, 0, 0, 0, 1, 0, 1, 0, 0), ex(1, 0, 1, 0, 30'h1C, 0, 32'hA5A5A5A5, S_REQ));
        step("fl4", vi(1, 1, 0, 0, 0, 1, 1, 1, 0, 0), ex(1, 0, 0, 0, 30'h1C, 0, 32'hA5A5A5A5, S_ACC));
        step("fl5", vi(1, 1, 0, 0, 0, 1, 1, 0, 32'h2468ACE0, 0),
             ex(0, 0, 1, 32'h2468ACE0, 30'h1C, 0, 32'hA5A5A5A5, S_ACC));
        step("fl6", vi(1, 1, 0, 0, 0, 0, 1, 1, 0, 0), ex(0, 1, 1, 0, 0, 1, 0, S_IDLE));

        // Reset during ACCESS: req/strobe release at once, registers clear next edge
        step("rs0", vi(0, 1, 30'h3F, 0, 0, 0, 0, 1, 0, 0), ex(1, 1, 1, 0, 0, 1, 0, S_IDLE));
        step("rs1", vi(1, 1, 0, 0, 0, 0, 0, 1, 0, 0), ex(1, 0, 1, 0, 30'h3F, 1, 0, S_REQ));
        step("rs2", vi(1, 1, 0, 0, 0, 0, 1, 1, 32'h77, 1), ex(0, 1, 1, 0, 30'h3F, 1, 0, S_ACC));
        step("rs3", vi(1, 1, 0, 0, 0, 0, 0, 0, 32'h77, 0), ex(0, 1, 1, 0, 0, 1, 0, S_IDLE));

`ifdef BUS_MASTER_IF_SPM_EN
        // Scratchpad hit bypasses the bus entirely
        step("sp0", vi(0, 1, {3'd1, 27'h5}, 0, 0, 0, 0, 0, 0, 0),
             ex(0, 1, 1, 32'h55AA55AA, 0, 1, 0, S_IDLE, 0));
        step("sp1", vi(0, 1, {3'd1, 27'h5}, 0, 0, 1, 0, 0, 0, 0),
             ex(0, 1, 1, 32'h55AA55AA, 0, 1, 0, S_IDLE, 1));
        step("sp2", vi(1, 1, 0, 0, 0, 0, 1, 1, 0, 0), ex(0, 1, 1, 0, 0, 1, 0, S_IDLE, 1));
`endif

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
